// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - walks the 24 solved knight moves and issues vertical/horizontal drive commands
module tour_cmd_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_busy
);

    localparam logic [4:0] LAST_MOVE = 5'd23;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;
    localparam logic [7:0] HDG_WEST  = 8'h3F;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] mv_indx_q, mv_indx_d;

    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE: begin
                if (start_tour) begin
                    state_d = VERT;
                end
            end
            VERT: begin
                if (clr_cmd_rdy) begin
                    state_d = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) begin
                    state_d = HORZ;
                end
            end
            HORZ: begin
                if (clr_cmd_rdy) begin
                    state_d = WAIT_H;
                end
            end
            WAIT_H: begin
                if (send_resp) begin
                    if (mv_indx_q == LAST_MOVE) begin
                        state_d   = IDLE;
                        mv_indx_d = 5'd0;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mv_indx_d = 5'd0;
            end
        endcase
    end

    // Each leg is fixed by the move bit; anything not one-hot becomes a zero-length leg.
    always_comb begin
        vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd0};
        horz_cmd = {OP_FANFARE, HDG_NORTH, 4'd0};
        case (move)
            8'h01: begin
                vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd2};
                horz_cmd = {OP_FANFARE, HDG_EAST,  4'd1};
            end
            8'h02: begin
                vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd2};
                horz_cmd = {OP_FANFARE, HDG_WEST,  4'd1};
            end
            8'h04: begin
                vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd1};
                horz_cmd = {OP_FANFARE, HDG_WEST,  4'd2};
            end
            8'h08: begin
                vert_cmd = {OP_MOVE,    HDG_SOUTH, 4'd1};
                horz_cmd = {OP_FANFARE, HDG_WEST,  4'd2};
            end
            8'h10: begin
                vert_cmd = {OP_MOVE,    HDG_SOUTH, 4'd2};
                horz_cmd = {OP_FANFARE, HDG_WEST,  4'd1};
            end
            8'h20: begin
                vert_cmd = {OP_MOVE,    HDG_SOUTH, 4'd2};
                horz_cmd = {OP_FANFARE, HDG_EAST,  4'd1};
            end
            8'h40: begin
                vert_cmd = {OP_MOVE,    HDG_SOUTH, 4'd1};
                horz_cmd = {OP_FANFARE, HDG_EAST,  4'd2};
            end
            8'h80: begin
                vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd1};
                horz_cmd = {OP_FANFARE, HDG_EAST,  4'd2};
            end
            default: begin
                vert_cmd = {OP_MOVE,    HDG_NORTH, 4'd0};
                horz_cmd = {OP_FANFARE, HDG_NORTH, 4'd0};
            end
        endcase
    end

    always_comb begin
        cmd       = cmd_UART;
        cmd_rdy   = cmd_rdy_UART;
        resp      = RESP_DONE;
        tour_busy = 1'b1;
        case (state_q)
            IDLE: begin
                tour_busy = 1'b0;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_ACK;
            end
            WAIT_V: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                resp    = RESP_ACK;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                resp    = RESP_ACK;
            end
            WAIT_H: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                // The acknowledge of the final leg tells the host the tour is complete.
                resp    = (mv_indx_q == LAST_MOVE) ? RESP_DONE : RESP_ACK;
            end
            default: begin
                cmd       = cmd_UART;
                cmd_rdy   = cmd_rdy_UART;
                resp      = RESP_DONE;
                tour_busy = 1'b0;
            end
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule
